// File: rtl/if_fetch.sv
// if_fetch: RV32I instruction-fetch stage with a single outstanding imem request, a one-entry hold buffer and flush/redirect.
// Optional rvalid watchdog (S_ERR, sticky fetch_err_o) is compiled in with IF_FETCH_TIMEOUT_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] NOP_INST       = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        fetch_err_o
);

  // state  | meaning
  // S_IDLE | single cycle after reset release
  // S_REQ  | request at pc_q, waiting for grant
  // S_WAIT | granted, waiting for rvalid
  // S_HOLD | decode stalled, fetched word parked in hold buffer
  // S_ERR  | rvalid timeout, only flush or reset leaves
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] out_pc_q;
  logic [31:0] out_inst_q;
  logic        out_valid_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_inst_q;
  logic        discard_q;
  logic [31:0] pc_plus4;
  logic [31:0] flush_pc_al;
  logic [1:0]  flush_pc_unused;

  assign pc_plus4        = pc_q + 32'd4;
  assign flush_pc_al     = {flush_pc_i[31:2], 2'b00};
  assign flush_pc_unused = flush_pc_i[1:0];

`ifdef IF_FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt_q;
  logic          err_q;
  assign fetch_err_o = err_q;
`else
  localparam int unsigned tmo_unused = TIMEOUT_CYCLES;
  assign fetch_err_o = 1'b0;
`endif

  assign imem_req_o   = (state_q == S_REQ);
  assign imem_addr_o  = pc_q;
  assign pc_o         = out_pc_q;
  assign inst_o       = out_inst_q;
  assign inst_valid_o = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      out_pc_q    <= RESET_PC;
      out_inst_q  <= NOP_INST;
      out_valid_q <= 1'b0;
      hold_pc_q   <= RESET_PC;
      hold_inst_q <= NOP_INST;
      discard_q   <= 1'b0;
`ifdef IF_FETCH_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= NOP_INST;
      pc_q        <= flush_pc_al;
`ifdef IF_FETCH_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        S_REQ: if (imem_gnt_i) begin
          // the word already granted belongs to the old path
          state_q   <= S_WAIT;
          discard_q <= 1'b1;
`ifdef IF_FETCH_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        S_WAIT: if (imem_rvalid_i) begin
          state_q   <= S_REQ;
          discard_q <= 1'b0;
        end else begin
          discard_q <= 1'b1;
        end
        S_HOLD: state_q <= S_REQ;
        S_ERR: begin
          state_q   <= S_REQ;
          discard_q <= 1'b0;
        end
        default: state_q <= state_q;
      endcase
    end else begin
      if (!stall_i) begin
        out_valid_q <= 1'b0;
        out_inst_q  <= NOP_INST;
      end
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: if (imem_gnt_i) begin
          state_q <= S_WAIT;
`ifdef IF_FETCH_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        S_WAIT: if (imem_rvalid_i) begin
          if (discard_q) begin
            discard_q <= 1'b0;
            state_q   <= S_REQ;
          end else if (!out_valid_q || !stall_i) begin
            out_pc_q    <= pc_q;
            out_inst_q  <= imem_rdata_i;
            out_valid_q <= 1'b1;
            pc_q        <= pc_plus4;
            state_q     <= S_REQ;
          end else begin
            hold_pc_q   <= pc_q;
            hold_inst_q <= imem_rdata_i;
            pc_q        <= pc_plus4;
            state_q     <= S_HOLD;
          end
        end else begin
`ifdef IF_FETCH_TIMEOUT_EN
          if (tmo_cnt_q == TMO_LAST) begin
            state_q     <= S_ERR;
            err_q       <= 1'b1;
            out_valid_q <= 1'b0;
            out_inst_q  <= NOP_INST;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
`endif
        end
        S_HOLD: if (!stall_i) begin
          out_pc_q    <= hold_pc_q;
          out_inst_q  <= hold_inst_q;
          out_valid_q <= 1'b1;
          state_q     <= S_REQ;
        end
        S_ERR: begin
`ifdef IF_FETCH_TIMEOUT_EN
          out_valid_q <= 1'b0;
          out_inst_q  <= NOP_INST;
`else
          state_q <= S_REQ;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
